// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over two channels of a raster-ordered feature map.
// Each pooled pixel is registered out on the edge that accepts the beat closing its window.
module maxpool2x2_stream #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IN_W   = 6,
   parameter int unsigned IN_H   = 6,
   localparam int unsigned HALF_W = IN_W / 2,
   localparam int unsigned POOL_N = (IN_W / 2) * (IN_H / 2),
   localparam int unsigned IDX_W  = (POOL_N > 1) ? $clog2(POOL_N) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [DATA_W-1:0] in_data_0,
   input  logic [DATA_W-1:0] in_data_1,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data_0,
   output logic [DATA_W-1:0] out_data_1,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last
);

   localparam int unsigned COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int unsigned ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;
   localparam int unsigned LB_AW = (HALF_W > 1) ? $clog2(HALF_W) : 1;

   logic [COL_W-1:0]  col, eff_col;
   logic [ROW_W-1:0]  row, eff_row;
   logic [DATA_W-1:0] pair_0, pair_1;
   logic [DATA_W-1:0] lb_0 [HALF_W];
   logic [DATA_W-1:0] lb_1 [HALF_W];
   logic [LB_AW-1:0]  lb_addr;
   logic [DATA_W-1:0] pairmax_0, pairmax_1, win_0, win_1;
   logic [IDX_W-1:0]  idx_c;
   logic              sof_c, col_end, row_end, done_c;

   // A start-of-frame beat is forced to (0,0) whatever the counters say.
   always_comb begin
      sof_c     = in_valid && in_sof;
      eff_col   = sof_c ? '0 : col;
      eff_row   = sof_c ? '0 : row;
      col_end   = (eff_col == COL_W'(IN_W - 1));
      row_end   = (eff_row == ROW_W'(IN_H - 1));
      lb_addr   = LB_AW'(eff_col >> 1);
      pairmax_0 = (in_data_0 > pair_0) ? in_data_0 : pair_0;
      pairmax_1 = (in_data_1 > pair_1) ? in_data_1 : pair_1;
      win_0     = (lb_0[lb_addr] > pairmax_0) ? lb_0[lb_addr] : pairmax_0;
      win_1     = (lb_1[lb_addr] > pairmax_1) ? lb_1[lb_addr] : pairmax_1;
      idx_c     = IDX_W'(eff_row >> 1) * IDX_W'(HALF_W) + IDX_W'(eff_col >> 1);
      done_c    = in_valid && eff_col[0] && eff_row[0];
   end

   // Even column fills the pair register, odd column on even row fills the line
   // buffer, odd column on odd row closes a window.
   always_ff @(posedge clk) begin
      if (reset) begin
         col        <= '0;
         row        <= '0;
         pair_0     <= '0;
         pair_1     <= '0;
         for (int unsigned i = 0; i < HALF_W; i++) begin
            lb_0[LB_AW'(i)] <= '0;
            lb_1[LB_AW'(i)] <= '0;
         end
         out_valid  <= 1'b0;
         out_data_0 <= '0;
         out_data_1 <= '0;
         out_idx    <= '0;
         out_last   <= 1'b0;
      end else begin
         out_valid <= done_c;
         out_last  <= done_c && col_end && row_end;
         if (in_valid) begin
            col <= col_end ? '0 : eff_col + 1'b1;
            if (col_end) begin
               row <= row_end ? '0 : eff_row + 1'b1;
            end else begin
               row <= eff_row;
            end
            if (!eff_col[0]) begin
               pair_0 <= in_data_0;
               pair_1 <= in_data_1;
            end else if (!eff_row[0]) begin
               lb_0[lb_addr] <= pairmax_0;
               lb_1[lb_addr] <= pairmax_1;
            end else begin
               out_data_0 <= win_0;
               out_data_1 <= win_1;
               out_idx    <= idx_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: drives 6x6 frames and checks pooled outputs and their
// exact cycle against a 2x2 max over the stored frame arrays.
module tb_maxpool2x2_stream;

   localparam int unsigned W = 6;
   localparam int unsigned H = 6;

   typedef struct packed {
      int         cyc;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [3:0] idx;
      logic       last;
   } out_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_sof = 1'b0;
   logic [7:0] in_data_0 = '0;
   logic [7:0] in_data_1 = '0;
   logic       out_valid;
   logic [7:0] out_data_0;
   logic [7:0] out_data_1;
   logic [3:0] out_idx;
   logic       out_last;

   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   out_t obs_q[$];
   out_t exp_q[$];
   out_t mon;
   logic [7:0] fr0 [H][W];
   logic [7:0] fr1 [H][W];
   int         bc  [H][W];

   maxpool2x2_stream #(.DATA_W(8), .IN_W(W), .IN_H(H)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
      .in_data_0(in_data_0), .in_data_1(in_data_1),
      .out_valid(out_valid), .out_data_0(out_data_0), .out_data_1(out_data_1),
      .out_idx(out_idx), .out_last(out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         mon.cyc  = cyc;
         mon.d0   = out_data_0;
         mon.d1   = out_data_1;
         mon.idx  = out_idx;
         mon.last = out_last;
         obs_q.push_back(mon);
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives the first n pixels of fr0/fr1 and records the cycle each beat is taken.
   task automatic send_frame(input int n, input bit sof, input int gap_pct);
      int g;
      for (int p = 0; p < n; p++) begin
         g = 0;
         while (g < 6 && int'($urandom_range(99)) < gap_pct) begin
            idle(1);
            g++;
         end
         in_valid  = 1'b1;
         in_sof    = sof && (p == 0);
         in_data_0 = fr0[p / W][p % W];
         in_data_1 = fr1[p / W][p % W];
         @(posedge clk);
         #1;
         bc[p / W][p % W] = cyc;
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   // Reference: each 2x2 window whose last pixel was sent yields its max, visible
   // in the cycle right after the closing beat is taken.
   task automatic add_expect(input int n);
      out_t       e;
      logic [7:0] m0, m1;
      for (int r = 1; r < H; r += 2) begin
         for (int c = 1; c < W; c += 2) begin
            if (r * W + c < n) begin
               m0 = 8'd0;
               m1 = 8'd0;
               for (int dr = 0; dr < 2; dr++) begin
                  for (int dc = 0; dc < 2; dc++) begin
                     if (fr0[r - 1 + dr][c - 1 + dc] > m0) m0 = fr0[r - 1 + dr][c - 1 + dc];
                     if (fr1[r - 1 + dr][c - 1 + dc] > m1) m1 = fr1[r - 1 + dr][c - 1 + dc];
                  end
               end
               e.cyc  = bc[r][c];
               e.d0   = m0;
               e.d1   = m1;
               e.idx  = 4'((r / 2) * (W / 2) + c / 2);
               e.last = (r == H - 1) && (c == W - 1);
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic fill_ramp();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            fr0[r][c] = 8'(r * W + c);
            fr1[r][c] = 8'(35 - (r * W + c));
         end
   endtask

   task automatic fill_rand();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            fr0[r][c] = 8'($urandom);
            fr1[r][c] = 8'($urandom);
         end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b1;
      in_data_0 = 8'hff;
      in_data_1 = 8'hff;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      in_valid = 1'b0;
      n_tests += 5;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b, want 0", out_valid); end
      if (out_data_0 !== 8'd0) begin n_fail++; $display("FAIL reset out_data_0: got %0d, want 0", out_data_0); end
      if (out_data_1 !== 8'd0) begin n_fail++; $display("FAIL reset out_data_1: got %0d, want 0", out_data_1); end
      if (out_idx !== 4'd0) begin n_fail++; $display("FAIL reset out_idx: got %0d, want 0", out_idx); end
      if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset out_last: got %b, want 0", out_last); end
      idle(2);
      n_tests++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset spurious outputs: got %0d, want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_ramp();
      out_t e, o;
      int   k;
      logic [7:0] want_d0 [9];
      want_d0 = '{8'd7, 8'd9, 8'd11, 8'd19, 8'd21, 8'd23, 8'd31, 8'd33, 8'd35};
      fill_ramp();
      send_frame(W * H, 1'b1, 0);
      add_expect(W * H);
      idle(3);
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
         n_tests += 2;
         if (o !== e) begin
            n_fail++;
            $display("FAIL ramp out: got cyc=%0d d0=%0d d1=%0d idx=%0d last=%b, want cyc=%0d d0=%0d d1=%0d idx=%0d last=%b",
                     o.cyc, o.d0, o.d1, o.idx, o.last, e.cyc, e.d0, e.d1, e.idx, e.last);
         end
         if (o.d0 !== want_d0[k] || o.d1 !== 8'(42 - want_d0[k])) begin
            n_fail++;
            $display("FAIL ramp const %0d: got d0=%0d d1=%0d, want d0=%0d d1=%0d", k, o.d0, o.d1, want_d0[k], 42 - want_d0[k]);
         end
         k++;
      end
      n_tests++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL ramp extra outputs: got %0d, want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_hot_pixel();
      out_t o;
      int   k;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            fr0[r][c] = 8'd0;
            fr1[r][c] = 8'd0;
         end
      fr0[3][4] = 8'd200;
      fr1[3][4] = 8'd200;
      send_frame(W * H, 1'b0, 0);
      idle(3);
      k = 0;
      n_tests++;
      if (obs_q.size() != 9) begin n_fail++; $display("FAIL hot count: got %0d, want 9", obs_q.size()); end
      while (obs_q.size() > 0) begin
         o = obs_q.pop_front();
         n_tests++;
         if (o.idx !== 4'(k) || o.d0 !== ((k == 5) ? 8'd200 : 8'd0) || o.d1 !== ((k == 5) ? 8'd200 : 8'd0)) begin
            n_fail++;
            $display("FAIL hot out %0d: got idx=%0d d0=%0d d1=%0d, want idx=%0d d=%0d", k, o.idx, o.d0, o.d1, k, (k == 5) ? 200 : 0);
         end
         k++;
      end
   endtask

   task automatic test_gaps();
      out_t e, o;
      fill_ramp();
      send_frame(W * H, 1'b1, 50);
      add_expect(W * H);
      idle(4);
      n_tests += 5;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gaps hold valid: got %b, want 0", out_valid); end
      if (out_last !== 1'b0) begin n_fail++; $display("FAIL gaps hold last: got %b, want 0", out_last); end
      if (out_idx !== 4'd8) begin n_fail++; $display("FAIL gaps hold idx: got %0d, want 8", out_idx); end
      if (out_data_0 !== 8'd35) begin n_fail++; $display("FAIL gaps hold d0: got %0d, want 35", out_data_0); end
      if (out_data_1 !== 8'd7) begin n_fail++; $display("FAIL gaps hold d1: got %0d, want 7", out_data_1); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL gaps out: got cyc=%0d d0=%0d d1=%0d idx=%0d last=%b, want cyc=%0d d0=%0d d1=%0d idx=%0d last=%b",
                     o.cyc, o.d0, o.d1, o.idx, o.last, e.cyc, e.d0, e.d1, e.idx, e.last);
         end
      end
      n_tests++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL gaps extra outputs: got %0d, want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      out_t e, o;
      fill_rand();
      send_frame(W * H, 1'b1, 0);
      add_expect(W * H);
      fill_rand();
      send_frame(W * H, 1'b0, 0);
      add_expect(W * H);
      idle(3);
      n_tests++;
      if (exp_q.size() != 18) begin n_fail++; $display("FAIL b2b model count: got %0d, want 18", exp_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL b2b out: got cyc=%0d d0=%0d d1=%0d idx=%0d last=%b, want cyc=%0d d0=%0d d1=%0d idx=%0d last=%b",
                     o.cyc, o.d0, o.d1, o.idx, o.last, e.cyc, e.d0, e.d1, e.idx, e.last);
         end
      end
      n_tests++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL b2b extra outputs: got %0d, want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_reset_mid();
      out_t e, o;
      fill_rand();
      send_frame(20, 1'b1, 0);
      add_expect(20);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      n_tests += 3;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid valid: got %b, want 0", out_valid); end
      if (out_idx !== 4'd0) begin n_fail++; $display("FAIL rstmid idx: got %0d, want 0", out_idx); end
      if (out_data_0 !== 8'd0) begin n_fail++; $display("FAIL rstmid d0: got %0d, want 0", out_data_0); end
      fill_rand();
      send_frame(W * H, 1'b0, 0);
      add_expect(W * H);
      idle(3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL rstmid out: got cyc=%0d d0=%0d d1=%0d idx=%0d last=%b, want cyc=%0d d0=%0d d1=%0d idx=%0d last=%b",
                     o.cyc, o.d0, o.d1, o.idx, o.last, e.cyc, e.d0, e.d1, e.idx, e.last);
         end
      end
      n_tests++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid extra outputs: got %0d, want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_sof_abort();
      out_t e, o;
      fill_rand();
      send_frame(10, 1'b0, 0);
      add_expect(10);
      fill_rand();
      send_frame(W * H, 1'b1, 30);
      add_expect(W * H);
      idle(3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL sof out: got cyc=%0d d0=%0d d1=%0d idx=%0d last=%b, want cyc=%0d d0=%0d d1=%0d idx=%0d last=%b",
                     o.cyc, o.d0, o.d1, o.idx, o.last, e.cyc, e.d0, e.d1, e.idx, e.last);
         end
      end
      n_tests++;
      if (obs_q.size() != 0) begin n_fail++; $display("FAIL sof extra outputs: got %0d, want 0", obs_q.size()); end
      obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_hot_pixel();
      test_gaps();
      test_back_to_back();
      test_reset_mid();
      test_sof_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
